// File: rtl/wide_add_stream_pkg.sv
// Shared definitions for the word-serial wide adder front/back end.
//   state_e     : operation sequencer states
//   calc_beats  : stream beats per N-bit word
//   calc_cnt_w  : width of the beat counter (at least 1 bit)
package wide_add_stream_pkg;

    typedef enum logic [1:0] {
        st_load_a,
        st_load_b,
        st_add,
        st_send
    } state_e;

    function automatic int unsigned calc_beats(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/full_adder_128.sv
// Combinational N-bit ripple-carry adder: {cout, sum} = a + b + cin.
// Ports:
//   a, b  in  N  operands
//   cin   in  1  carry-in
//   sum   out N  sum
//   cout  out 1  carry-out
module full_adder_128 #(
    parameter int unsigned N = 128
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/wide_add_stream.sv
// Word-serial wrapper around the wide adder. Collects operand A, then B
// (least-significant beat first, carry-in taken with the first A beat),
// adds them in one cycle, then streams the sum back out.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input beat handshake, in_data W-bit beat, in_cin carry-in
//   out_valid/out_ready output beat handshake, out_data W-bit sum beat
//   out_last           final sum beat marker
//   out_cout           carry-out, only on the final beat
// All outputs are registered.
module wide_add_stream
    import wide_add_stream_pkg::*;
#(
    parameter int unsigned N = 128,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_cout
);

    localparam int unsigned BEATS = calc_beats(N, W);
    localparam int unsigned CW    = calc_cnt_w(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam bit SINGLE = (BEATS == 1);

    if ((N % W) != 0 || W == 0) begin : g_bad_width
        $error("wide_add_stream: N must be a non-zero multiple of W");
    end

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  sum_q;
    logic          cin_q;
    logic          cout_q;

    logic [N-1:0]  add_sum;
    logic          add_cout;

    logic in_hs;

    assign cnt_inc = cnt_q + 1'b1;
    assign in_hs   = in_valid & in_ready;

    full_adder_128 #(
        .N (N)
    ) u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= st_load_a;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cin_q     <= 1'b0;
            cout_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else begin
            unique case (state_q)
                st_load_a: begin
                    // in_ready comes up one clock after reset release
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        a_q[cnt_q*W +: W] <= in_data;
                        if (cnt_q == '0) begin
                            cin_q <= in_cin;
                        end
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= st_load_b;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                st_load_b: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        b_q[cnt_q*W +: W] <= in_data;
                        if (cnt_q == LAST) begin
                            cnt_q    <= '0;
                            in_ready <= 1'b0;
                            state_q  <= st_add;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                st_add: begin
                    sum_q     <= add_sum;
                    cout_q    <= add_cout;
                    // first output beat is loaded straight from the adder
                    out_valid <= 1'b1;
                    out_data  <= add_sum[W-1:0];
                    out_last  <= SINGLE;
                    out_cout  <= SINGLE & add_cout;
                    state_q   <= st_send;
                end
                st_send: begin
                    if (out_ready) begin
                        if (cnt_q == LAST) begin
                            cnt_q     <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            out_cout  <= 1'b0;
                            in_ready  <= 1'b1;
                            state_q   <= st_load_a;
                        end else begin
                            cnt_q    <= cnt_inc;
                            out_data <= sum_q[cnt_inc*W +: W];
                            out_last <= (cnt_inc == LAST);
                            out_cout <= cout_q & (cnt_inc == LAST);
                        end
                    end
                end
                default: state_q <= st_load_a;
            endcase
        end
    end

endmodule
